toggle_activity_monitor: RTL and testbench
==========================================

// Module: toggle_activity_monitor
// PURPOSE
//   Parametrised, multi-channel successor to the single-bit INV/AND cell models.
//   Counts 0->1 and 1->0 transitions on NUM_CH net-activity probes over a programmable window.
//   At window end it drains one saturating count per channel over a valid/ready stream.
//   Sits between the gate-level netlist probes and the power/thermal model input FIFO.
// PARAMETERS
//   NUM_CH   4    number of monitored signals (>=1)
//   CNT_W    16   per-channel toggle counter width
//   WIN_W    16   window-length register width
//   CH_W     $clog2(NUM_CH) (min 1), derived localparam; channel index width
// PORTS
//   CK         in   1        clock, rising edge
//   RN         in   1        asynchronous active-low reset
//   en         in   1        run enable
//   win_len    in   WIN_W    window length in cycles; 0 treated as 1
//   sig_in     in   NUM_CH   monitored signals, synchronous to CK
//   out_valid  out  1        count beat valid
//   out_ready  in   1        consumer accepts beat when out_valid&&out_ready
//   out_ch     out  CH_W     channel index of current beat
//   out_count  out  CNT_W    toggle count of channel out_ch
//   out_sat    out  1        count of out_ch saturated during the window
//   busy       out  1        state != IDLE
// BEHAVIOUR
//   Clock/reset: one clock; reset is asynchronous and active-low.
//   - RN=0 clears all state: FSM=IDLE, counters/sat flags/prev=0, all outputs 0.
//   prev[NUM_CH-1:0] <= sig_in every cycle, in every state (reset value 0).
//   toggle[i] = sig_in[i] ^ prev[i].
//   FSM states: IDLE, COUNT, DRAIN.
//   IDLE
//   - en=1: latch max(win_len,1) into remaining; clear counters and sat; go to COUNT.
//   COUNT, every cycle
//   - counter[i] += toggle[i].
//   - Saturates at 2^CNT_W-1 and sets sticky sat[i]; never wraps.
//   - remaining decrements.
//   - On the cycle with remaining==1 (the Wth counted cycle, toggles included): snapshot
//     counters/sat into drain regs; idx=0; go to DRAIN.
//   - en=0 in COUNT: abort; go to IDLE next cycle; counts discarded; no beats emitted.
//   - Abort takes priority over window end in the same cycle.
//   DRAIN
//   - out_valid=1, out_ch=idx, out_count/out_sat from drain regs[idx].
//   - Toggles are not counted.
//   - Outputs are stable while out_valid && !out_ready.
//   - Handshake: idx advances on out_valid && out_ready.
//   - On the handshake with idx==NUM_CH-1:
//     - en=1: clear counters/sat, reload window from win_len, go to COUNT.
//     - en=0: go to IDLE.
//   - en is ignored mid-DRAIN; the drain always completes unless RN is asserted.
//   Outputs are registered; out_valid rises the cycle after the window-end cycle.
//   Drain takes at least NUM_CH cycles; no beat is dropped or duplicated.
//   out_valid=0, out_ch=0, out_count=0, out_sat=0 whenever not in DRAIN.
// TESTING
//   1. Reset
//      Stimulus: RN=0 mid-DRAIN with out_valid=1.
//      Required: out_valid=0, busy=0, out_count=0 immediately (async).
//      Required: after release, no beats until en rises.
//   2. Basic count
//      Stimulus: NUM_CH=4, win_len=8, sig_in=0 held in IDLE; en=1.
//      Stimulus: ch0 toggles every cycle; ch1 const; ch2 single toggle; ch3 const.
//      Required: beats (ch,count) = (0,8) (1,0) (2,1) (3,0); out_sat=0.
//   3. Saturation
//      Stimulus: CNT_W=4, win_len=20, ch0 toggles every cycle.
//      Required: ch0 beat count=15, out_sat=1; other channels 0/0.
//   4. Backpressure
//      Stimulus: out_ready=0 for 5 cycles while out_ch=1.
//      Required: out_valid, out_ch=1 and out_count hold constant.
//      Required: all 4 beats are then delivered exactly once.
//   5. Abort
//      Stimulus: en=0 on the 3rd COUNT cycle of win_len=8.
//      Required: IDLE next cycle, no out_valid.
//      Required: on re-enable, fresh counts that exclude the aborted activity.
//   6. Edge window
//      Stimulus: win_len=0, en held 1, ch0 toggles every cycle.
//      Required: back-to-back 1-cycle windows, each with ch0 count=1.
//      Required: COUNT re-entered the cycle after the last beat.

Source files
------------

// File: rtl/toggle_activity_monitor.sv
// Multi-channel toggle activity monitor: counts per-probe transitions over a programmable
// window, then drains one saturating count per channel over a valid/ready stream.
module toggle_activity_monitor #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 16,
  parameter  int WIN_W  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              en,
  input  logic [WIN_W-1:0]  win_len,
  input  logic [NUM_CH-1:0] sig_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

  state_t                         state_q, state_d;
  logic [NUM_CH-1:0]              prev_q, prev_d;
  logic [WIN_W-1:0]               remaining_q, remaining_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]              sat_q, sat_d;
  logic                           out_valid_q, out_valid_d;
  logic [CH_W-1:0]                out_ch_q, out_ch_d;
  logic [CNT_W-1:0]               out_count_q, out_count_d;
  logic                           out_sat_q, out_sat_d;

  logic [NUM_CH-1:0]              toggle;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_inc;
  logic [NUM_CH-1:0]              sat_inc;
  logic [WIN_W-1:0]               win_eff;
  logic [CH_W-1:0]                ch_next;

  assign toggle  = sig_in ^ prev_q;
  assign win_eff = (win_len == '0) ? WIN_W'(1) : win_len;
  assign ch_next = out_ch_q + CH_W'(1);

  // The carry out of the widened add marks a lost toggle: clamp and flag it.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W:0] sum;
    assign sum         = {1'b0, cnt_q[gi]} + {{CNT_W{1'b0}}, toggle[gi]};
    assign cnt_inc[gi] = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    assign sat_inc[gi] = sat_q[gi] | sum[CNT_W];
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = sig_in;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    out_ch_d    = '0;
    out_count_d = '0;
    out_sat_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          remaining_d = win_eff;
          cnt_d       = '0;
          sat_d       = '0;
          state_d     = COUNT;
        end
      end

      COUNT: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          cnt_d       = cnt_inc;
          sat_d       = sat_inc;
          remaining_d = remaining_q - WIN_W'(1);
          if (remaining_q == WIN_W'(1)) begin
            state_d     = DRAIN;
            out_valid_d = 1'b1;
            out_ch_d    = '0;
            out_count_d = cnt_inc[0];
            out_sat_d   = sat_inc[0];
          end
        end
      end

      DRAIN: begin
        // Counters are frozen while draining, so they double as the drain snapshot
        // and out_ch_q is the drain index.
        out_valid_d = 1'b1;
        out_ch_d    = out_ch_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        if (out_ready) begin
          if (out_ch_q == LAST_CH) begin
            out_valid_d = 1'b0;
            out_ch_d    = '0;
            out_count_d = '0;
            out_sat_d   = 1'b0;
            if (en) begin
              remaining_d = win_eff;
              cnt_d       = '0;
              sat_d       = '0;
              state_d     = COUNT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            out_ch_d    = ch_next;
            out_count_d = cnt_q[ch_next];
            out_sat_d   = sat_q[ch_next];
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
      sat_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Bench for toggle_activity_monitor: a vector table for the basic window, directed corner
// sequences, and random traffic against a beat-queue reference model.
module tb_toggle_activity_monitor;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
  localparam int WIN_W  = 8;
  localparam int CH_W   = 2;
  localparam int CMAX   = 15;

  logic              CK = 1'b0;
  logic              RN = 1'b0;
  logic              en = 1'b0;
  logic [WIN_W-1:0]  win_len = '0;
  logic [NUM_CH-1:0] sig_in = '0;
  logic              out_ready = 1'b1;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;
  logic              busy;

  toggle_activity_monitor #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W),
    .WIN_W (WIN_W)
  ) dut (
    .CK       (CK),
    .RN       (RN),
    .en       (en),
    .win_len  (win_len),
    .sig_in   (sig_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_count(out_count),
    .out_sat  (out_sat),
    .busy     (busy)
  );

  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 counting, 2 draining a queue of finished beats.
  typedef struct {
    int ch;
    int cnt;
    int sat;
  } beat_t;

  int                m_phase;
  int                m_left;
  int                m_sum [NUM_CH];
  logic [NUM_CH-1:0] m_prev;
  beat_t             m_q [$];

  function automatic void model_reset();
    m_phase = 0;
    m_left  = 0;
    m_prev  = '0;
    m_q.delete();
    for (int i = 0; i < NUM_CH; i++) m_sum[i] = 0;
  endfunction

  function automatic void model_start();
    m_left  = (win_len == 0) ? 1 : int'(win_len);
    m_phase = 1;
    for (int i = 0; i < NUM_CH; i++) m_sum[i] = 0;
  endfunction

  function automatic void model_edge();
    logic [NUM_CH-1:0] tg;
    beat_t b;
    tg     = sig_in ^ m_prev;
    m_prev = sig_in;
    case (m_phase)
      0: if (en) model_start();
      1: begin
        if (!en) begin
          m_phase = 0;
        end else begin
          for (int i = 0; i < NUM_CH; i++) m_sum[i] += int'(tg[i]);
          m_left--;
          if (m_left == 0) begin
            for (int i = 0; i < NUM_CH; i++) begin
              b.ch  = i;
              b.cnt = (m_sum[i] > CMAX) ? CMAX : m_sum[i];
              b.sat = (m_sum[i] > CMAX) ? 1 : 0;
              m_q.push_back(b);
            end
            m_phase = 2;
          end
        end
      end
      default: begin
        if (out_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            if (en) model_start();
            else m_phase = 0;
          end
        end
      end
    endcase
  endfunction

  task automatic check_model();
    int ev;
    ev = (m_phase == 2) ? 1 : 0;
    check("valid", int'(out_valid), ev);
    check("ch",    int'(out_ch),    ev ? m_q[0].ch  : 0);
    check("count", int'(out_count), ev ? m_q[0].cnt : 0);
    check("sat",   int'(out_sat),   ev ? m_q[0].sat : 0);
    check("busy",  int'(busy),      (m_phase != 0) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge CK);
    if (!RN) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic step(input logic e, input int wl, input logic [NUM_CH-1:0] s, input logic r);
    en        = e;
    win_len   = WIN_W'(wl);
    sig_in    = s;
    out_ready = r;
    tick();
    check_model();
  endtask

  typedef struct {
    logic              en;
    logic [NUM_CH-1:0] sig;
    logic              rdy;
    logic              valid;
    logic [CH_W-1:0]   ch;
    logic [CNT_W-1:0]  cnt;
    logic              sat;
    logic              busy;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic [3:0] s, input logic r, input logic v,
                              input logic [1:0] c, input logic [3:0] n, input logic st,
                              input logic b);
    vec_t x;
    x.en = e; x.sig = s; x.rdy = r; x.valid = v; x.ch = c; x.cnt = n; x.sat = st; x.busy = b;
    return x;
  endfunction

  vec_t tbl [15];

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    int beats;
    logic r;

    // Basic window: win_len=8, ch0 toggles every cycle, ch2 toggles once.
    tbl[0]  = mk(0, 4'b0000, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 4'b0000, 1, 0, 0, 0, 0, 1);
    tbl[2]  = mk(1, 4'b0001, 1, 0, 0, 0, 0, 1);
    tbl[3]  = mk(1, 4'b0000, 1, 0, 0, 0, 0, 1);
    tbl[4]  = mk(1, 4'b0101, 1, 0, 0, 0, 0, 1);
    tbl[5]  = mk(1, 4'b0100, 1, 0, 0, 0, 0, 1);
    tbl[6]  = mk(1, 4'b0101, 1, 0, 0, 0, 0, 1);
    tbl[7]  = mk(1, 4'b0100, 1, 0, 0, 0, 0, 1);
    tbl[8]  = mk(1, 4'b0101, 1, 0, 0, 0, 0, 1);
    tbl[9]  = mk(1, 4'b0100, 1, 1, 0, 8, 0, 1);
    tbl[10] = mk(0, 4'b0101, 1, 1, 1, 0, 0, 1);
    tbl[11] = mk(0, 4'b0100, 1, 1, 2, 1, 0, 1);
    tbl[12] = mk(0, 4'b0101, 1, 1, 3, 0, 0, 1);
    tbl[13] = mk(0, 4'b0100, 1, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 4'b0000, 1, 0, 0, 0, 0, 0);

    model_reset();
    RN = 1'b0;
    repeat (2) tick();
    check_model();
    RN = 1'b1;

    for (int i = 0; i < 15; i++) begin
      en = tbl[i].en; win_len = 8; sig_in = tbl[i].sig; out_ready = tbl[i].rdy;
      tick();
      check($sformatf("t2_valid[%0d]", i), int'(out_valid), int'(tbl[i].valid));
      check($sformatf("t2_ch[%0d]", i),    int'(out_ch),    int'(tbl[i].ch));
      check($sformatf("t2_count[%0d]", i), int'(out_count), int'(tbl[i].cnt));
      check($sformatf("t2_sat[%0d]", i),   int'(out_sat),   int'(tbl[i].sat));
      check($sformatf("t2_busy[%0d]", i),  int'(busy),      int'(tbl[i].busy));
    end

    // Asynchronous reset while a beat is presented.
    step(1, 3, 4'b0000, 1);
    step(1, 3, 4'b0011, 0);
    step(1, 3, 4'b0000, 0);
    step(1, 3, 4'b0011, 0);
    check("pre_rst_valid", int'(out_valid), 1);
    #2;
    RN = 1'b0;
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_count", int'(out_count), 0);
    check("rst_ch",    int'(out_ch), 0);
    model_reset();
    step(1, 3, 4'b0101, 1);
    RN = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 3, 4'($urandom), 1);

    // Saturation: 20 toggles into a 4-bit counter.
    for (int i = 0; i < 30; i++) begin
      step(i < 21, 20, {3'b000, ~sig_in[0]}, 1);
      if (out_valid && out_ch == 0) begin
        check("sat_count", int'(out_count), CMAX);
        check("sat_flag",  int'(out_sat), 1);
      end
    end

    // Backpressure: hold ready low for 5 cycles while channel 1 is presented.
    hold  = 0;
    beats = 0;
    for (int i = 0; i < 20; i++) begin
      r = 1'b1;
      if (m_phase == 2 && m_q[0].ch == 1 && hold < 5) begin
        r = 1'b0;
        hold++;
      end
      if (out_valid && r) beats++;
      step(i < 4, 3, 4'($urandom), r);
    end
    check("bp_beats", beats, 4);

    // Abort on the third counting cycle, then a fresh window.
    for (int i = 0; i < 6; i++) step(i < 3, 8, {2'b00, i[0], 1'b0}, 1);
    check("abort_valid", int'(out_valid), 0);
    for (int i = 0; i < 12; i++) step(i < 5, 4, {i == 2, 2'b00, i[0]}, 1);

    // Zero-length window: back-to-back single-cycle windows.
    for (int i = 0; i < 30; i++) begin
      step(1, 0, {3'b000, ~sig_in[0]}, 1);
      if (out_valid && out_ch == 0) check("w0_count", int'(out_count), 1);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 4'b0000, 1);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 15) != 0, $urandom_range(0, 24), 4'($urandom),
           $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
